// File: rtl/adder_tree_arbiter.sv
// adder_tree_arbiter: round-robin front end for one shared, non-stalling,
// pipelined adder tree. It grants at most one requester per cycle, forwards
// that vector to the tree, follows it with a requester tag through a shadow
// pipeline of the same depth as the tree, and returns the sum to the requester.
// Each requester may have at most MAX_OUT vectors in flight at once.
module adder_tree_arbiter #(
   parameter int SIZE    = 10,
   parameter int NUM     = 1024,
   parameter int NREQ    = 4,
   parameter int LAT     = 10,
   parameter int MAX_OUT = 4,
   localparam int IDW    = $clog2(NREQ),
   localparam int CW     = $clog2(MAX_OUT + 1),
   localparam int VW     = NUM * SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*VW-1:0]   req_data,
   output logic [VW-1:0]        tree_din,
   input  logic [SIZE-1:0]      tree_dout,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [SIZE-1:0]      rsp_data,
   output logic                 idle
);

   logic [IDW-1:0]          ptr;
   logic [NREQ-1:0]         eligible;
   logic                    grant_any;
   logic [IDW-1:0]          grant_id;
   logic [CW-1:0]           outstanding [NREQ];
   logic [LAT-1:0]          tag_valid;
   logic [LAT-1:0][IDW-1:0] tag_id;

   // A requester is eligible if it has a vector and a free credit; a credit
   // being returned by this cycle's response already counts as free.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NREQ; i++) begin
         eligible[i] = req_valid[i] &&
                       ((outstanding[i] < CW'(MAX_OUT)) ||
                        (rsp_valid && (rsp_id == IDW'(i))));
      end
   end

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      logic [IDW:0] cand;
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int off = 1; off <= NREQ; off++) begin
         cand = {1'b0, ptr} + (IDW+1)'(off);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!grant_any && eligible[cand[IDW-1:0]]) begin
            grant_any = 1'b1;
            grant_id  = cand[IDW-1:0];
         end
      end
      if (!rst_n) begin
         grant_any = 1'b0;
      end
   end

   // One-hot ready and the granted vector steered onto the tree input.
   always_comb begin
      req_ready = '0;
      tree_din  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_any && (grant_id == IDW'(i))) begin
            req_ready[i] = 1'b1;
            tree_din     = req_data[i*VW +: VW];
         end
      end
   end

   // Pointer remembers the last winner so it drops to lowest priority next.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= IDW'(NREQ - 1);
      end else if (grant_any) begin
         ptr <= grant_id;
      end
   end

   // Tag shadow pipeline, same depth as the tree and never stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_valid <= '0;
         tag_id    <= '0;
      end else begin
         tag_valid[0] <= grant_any;
         tag_id[0]    <= grant_id;
         for (int k = 1; k < LAT; k++) begin
            tag_valid[k] <= tag_valid[k-1];
            tag_id[k]    <= tag_id[k-1];
         end
      end
   end

   // Response register pairs the emerging tag with the tree's sum.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= tag_valid[LAT-1];
         if (tag_valid[LAT-1]) begin
            rsp_id   <= tag_id[LAT-1];
            rsp_data <= tree_dout;
         end
      end
   end

   // Per-requester credit counters: up on grant, down on returned response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            outstanding[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant_any && (grant_id == IDW'(i)) &&
                !(rsp_valid && (rsp_id == IDW'(i)))) begin
               outstanding[i] <= outstanding[i] + CW'(1);
            end else if (!(grant_any && (grant_id == IDW'(i))) &&
                         rsp_valid && (rsp_id == IDW'(i))) begin
               outstanding[i] <= outstanding[i] - CW'(1);
            end
         end
      end
   end

   assign idle = ~(|tag_valid) & ~rsp_valid;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Directed bench for adder_tree_arbiter with NUM=4, LAT=2, MAX_OUT=2.
// A small behavioural two-stage adder stands in for the external tree.
module tb_adder_tree_arbiter;

   localparam int SIZE    = 10;
   localparam int NUM     = 4;
   localparam int NREQ    = 4;
   localparam int LAT     = 2;
   localparam int MAX_OUT = 2;
   localparam int VW      = NUM * SIZE;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*VW-1:0] req_data;
   logic [VW-1:0]      tree_din;
   logic [SIZE-1:0]    tree_dout;
   logic               rsp_valid;
   logic [1:0]         rsp_id;
   logic [SIZE-1:0]    rsp_data;
   logic               idle;

   int vectors    = 0;
   int miscompares = 0;

   logic [SIZE-1:0] tree_p0;
   logic [SIZE-1:0] tree_p1;

   // Operand vectors {op3, op2, op1, op0}; sums 0 (wraps), 26, 10, 1000.
   localparam logic [VW-1:0] VEC0 = {10'd1,   10'd1,   10'd1023, 10'd1023};
   localparam logic [VW-1:0] VEC1 = {10'd8,   10'd7,   10'd6,    10'd5};
   localparam logic [VW-1:0] VEC2 = {10'd4,   10'd3,   10'd2,    10'd1};
   localparam logic [VW-1:0] VEC3 = {10'd400, 10'd300, 10'd200,  10'd100};

   logic [3:0] rr_ready [5];
   logic       rr_valid [5];
   logic [1:0] rr_id    [5];
   logic [9:0] rr_data  [5];

   adder_tree_arbiter #(
      .SIZE(SIZE), .NUM(NUM), .NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_data(req_data),
      .tree_din(tree_din),
      .tree_dout(tree_dout),
      .rsp_valid(rsp_valid),
      .rsp_id(rsp_id),
      .rsp_data(rsp_data),
      .idle(idle)
   );

   always #5 clk = ~clk;

   function automatic logic [SIZE-1:0] vec_sum(input logic [VW-1:0] v);
      logic [SIZE-1:0] s;
      s = '0;
      for (int k = 0; k < NUM; k++) begin
         s = s + v[k*SIZE +: SIZE];
      end
      return s;
   endfunction

   // Stand-in for the external tree: two register stages, modulo-2^SIZE sum.
   always @(posedge clk) begin
      tree_p0 <= vec_sum(tree_din);
      tree_p1 <= tree_p0;
   end
   assign tree_dout = tree_p1;

   // Advance one cycle, drive the inputs for it, and let them settle.
   task automatic apply_stimulus(input logic rst_val, input logic [3:0] valid);
      @(posedge clk);
      #1;
      rst_n     = rst_val;
      req_valid = valid;
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rr_ready = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      rr_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      rr_id    = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
      rr_data  = '{10'd0, 10'd0, 10'd0, 10'd26, 10'd10};

      rst_n     = 1'b0;
      req_valid = 4'hF;
      req_data  = {VEC3, VEC2, VEC1, VEC0};

      // Held in reset with every requester asking.
      apply_stimulus(1'b0, 4'hF);
      apply_stimulus(1'b0, 4'hF);
      check_output("rst_ready", req_ready, 4'b0000);
      check_output("rst_rsp_valid", rsp_valid, 1'b0);
      check_output("rst_rsp_id", rsp_id, 2'd0);
      check_output("rst_rsp_data", rsp_data, 10'd0);
      check_output("rst_idle", idle, 1'b1);
      check_output("rst_tree_din", tree_din, 40'd0);

      // Cycles 0..4 quiet.
      for (int c = 0; c < 5; c++) begin
         apply_stimulus(1'b1, 4'b0000);
      end
      check_output("c4_idle", idle, 1'b1);
      check_output("c4_ready", req_ready, 4'b0000);

      // Single request from requester 2 in cycle 5.
      apply_stimulus(1'b1, 4'b0100);
      check_output("c5_ready", req_ready, 4'b0100);
      check_output("c5_tree_din", tree_din, VEC2);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c6_idle", idle, 1'b0);
      check_output("c6_rsp_valid", rsp_valid, 1'b0);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c7_idle", idle, 1'b0);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c8_rsp_valid", rsp_valid, 1'b1);
      check_output("c8_rsp_id", rsp_id, 2'd2);
      check_output("c8_rsp_data", rsp_data, 10'd10);
      check_output("c8_idle", idle, 1'b0);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c9_idle", idle, 1'b1);
      check_output("c9_rsp_valid", rsp_valid, 1'b0);
      check_output("c9_rsp_id_hold", rsp_id, 2'd2);
      check_output("c9_rsp_data_hold", rsp_data, 10'd10);

      // Wrap-around sum from requester 0.
      apply_stimulus(1'b1, 4'b0001);
      check_output("c10_ready", req_ready, 4'b0001);
      apply_stimulus(1'b1, 4'b0000);
      apply_stimulus(1'b1, 4'b0000);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c13_rsp_valid", rsp_valid, 1'b1);
      check_output("c13_rsp_id", rsp_id, 2'd0);
      check_output("c13_rsp_data", rsp_data, 10'd0);

      // Credit limit on requester 1.
      apply_stimulus(1'b1, 4'b0010);
      check_output("c14_ready", req_ready, 4'b0010);
      apply_stimulus(1'b1, 4'b0010);
      check_output("c15_ready", req_ready, 4'b0010);
      apply_stimulus(1'b1, 4'b0010);
      check_output("c16_ready_blocked", req_ready, 4'b0000);
      check_output("c16_tree_din_zero", tree_din, 40'd0);
      apply_stimulus(1'b1, 4'b0010);
      check_output("c17_rsp_valid", rsp_valid, 1'b1);
      check_output("c17_rsp_id", rsp_id, 2'd1);
      check_output("c17_ready_credit", req_ready, 4'b0010);
      apply_stimulus(1'b1, 4'b0010);
      check_output("c18_ready_credit", req_ready, 4'b0010);

      // Requester 1 blocked is skipped; requester 3 wins and takes the pointer.
      apply_stimulus(1'b1, 4'b1010);
      check_output("c19_rsp_valid", rsp_valid, 1'b0);
      check_output("c19_ready_skip", req_ready, 4'b1000);
      apply_stimulus(1'b1, 4'b1010);
      check_output("c20_ready_after_ptr3", req_ready, 4'b0010);
      check_output("c20_rsp_id", rsp_id, 2'd1);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c21_rsp_id", rsp_id, 2'd1);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c22_rsp_id", rsp_id, 2'd3);
      check_output("c22_rsp_data", rsp_data, 10'd1000);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c23_rsp_id", rsp_id, 2'd1);
      check_output("c23_rsp_data", rsp_data, 10'd26);

      // Load the pipeline, then reset mid-flight.
      apply_stimulus(1'b1, 4'hF);
      check_output("c24_idle", idle, 1'b1);
      check_output("c24_ready", req_ready, 4'b0100);
      apply_stimulus(1'b1, 4'hF);
      check_output("c25_ready", req_ready, 4'b1000);
      apply_stimulus(1'b1, 4'hF);
      check_output("c26_ready", req_ready, 4'b0001);
      apply_stimulus(1'b0, 4'hF);
      check_output("c27_ready_in_reset", req_ready, 4'b0000);
      check_output("c27_rsp_valid", rsp_valid, 1'b1);
      check_output("c27_rsp_id", rsp_id, 2'd2);
      apply_stimulus(1'b1, 4'hF);
      check_output("c28_rsp_valid", rsp_valid, 1'b0);
      check_output("c28_rsp_id", rsp_id, 2'd0);
      check_output("c28_rsp_data", rsp_data, 10'd0);
      check_output("c28_idle", idle, 1'b1);
      check_output("c28_ready", req_ready, 4'b0001);

      // Continuous round robin after reset, cycles 29..33.
      for (int j = 0; j < 5; j++) begin
         apply_stimulus(1'b1, 4'hF);
         check_output($sformatf("rr%0d_ready", j), req_ready, rr_ready[j]);
         check_output($sformatf("rr%0d_rsp_valid", j), rsp_valid, rr_valid[j]);
         if (rr_valid[j]) begin
            check_output($sformatf("rr%0d_rsp_id", j), rsp_id, rr_id[j]);
            check_output($sformatf("rr%0d_rsp_data", j), rsp_data, rr_data[j]);
         end
      end

      // Drain cycles 34..37.
      apply_stimulus(1'b1, 4'b0000);
      check_output("c34_rsp_id", rsp_id, 2'd3);
      check_output("c34_rsp_data", rsp_data, 10'd1000);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c35_rsp_id", rsp_id, 2'd0);
      check_output("c35_rsp_data", rsp_data, 10'd0);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c36_rsp_valid", rsp_valid, 1'b1);
      check_output("c36_rsp_id", rsp_id, 2'd1);
      check_output("c36_rsp_data", rsp_data, 10'd26);
      apply_stimulus(1'b1, 4'b0000);
      check_output("c37_rsp_valid", rsp_valid, 1'b0);
      check_output("c37_idle", idle, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
